// File: rtl/bipolar_pulse_gen_if.sv
// Pulse generator bus: trigger/amplitude request in, sample stream and status out.
interface bipolar_pulse_gen_if;
    logic               trig;
    logic [14:0]        amp;
    logic signed [15:0] Y;
    logic               outN;
    logic               outP;
    logic               busy;
    logic [7:0]         missed;

    modport master (
        output trig, amp,
        input  Y, outN, outP, busy, missed
    );

    modport slave (
        input  trig, amp,
        output Y, outN, outP, busy, missed
    );
endinterface

// File: rtl/bipolar_pulse_gen.sv
// Bipolar pulse shaper: linear rise to amp, fall into a negative lobe of depth
// amp>>NEG_SHIFT, linear return to zero, then a holdoff before re-arming.
module bipolar_pulse_gen #(
    parameter int RISE_STEP = 250,
    parameter int FALL_STEP = 101,
    parameter int NEG_SHIFT = 1,
    parameter int RET_STEP  = 201,
    parameter int HOLD      = 4
) (
    input  logic              clk,
    input  logic              clr,
    bipolar_pulse_gen_if.slave bus
);
    localparam int HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int HOLD_INIT = (HOLD > 0) ? HOLD - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_FALL,
        S_RETURN,
        S_HOLDOFF
    } state_t;

    state_t             state_q;
    logic signed [15:0] y_q;
    logic [14:0]        amp_q;
    logic               outn_q;
    logic               outp_q;
    logic               busy_q;
    logic [7:0]         missed_q;
    logic [HOLD_W-1:0]  hold_q;

    logic               trig_valid;
    logic signed [16:0] y_ext;
    logic signed [16:0] amp_ext;
    logic signed [16:0] neg_lim;
    logic signed [16:0] rise_sum;
    logic signed [16:0] fall_sum;
    logic signed [16:0] ret_sum;

    assign trig_valid = bus.trig && (bus.amp != 15'd0);

    // 17-bit signed working width so no step can wrap past the 16-bit range.
    assign y_ext    = {y_q[15], y_q};
    assign amp_ext  = {2'b00, amp_q};
    assign neg_lim  = -$signed({2'b00, amp_q >> NEG_SHIFT});
    assign rise_sum = y_ext + $signed(17'(RISE_STEP));
    assign fall_sum = y_ext - $signed(17'(FALL_STEP));
    assign ret_sum  = y_ext + $signed(17'(RET_STEP));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            y_q      <= '0;
            amp_q    <= '0;
            outn_q   <= 1'b0;
            outp_q   <= 1'b0;
            busy_q   <= 1'b0;
            missed_q <= '0;
            hold_q   <= '0;
        end else begin
            outn_q <= 1'b0;
            outp_q <= 1'b0;

            if (trig_valid && (state_q != S_IDLE) && (missed_q != 8'd255)) begin
                missed_q <= missed_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    y_q <= '0;
                    if (trig_valid) begin
                        amp_q   <= bus.amp;
                        state_q <= S_RISE;
                        busy_q  <= 1'b1;
                    end
                end
                S_RISE: begin
                    if (rise_sum >= amp_ext) begin
                        y_q     <= $signed({1'b0, amp_q});
                        state_q <= S_FALL;
                    end else begin
                        y_q <= rise_sum[15:0];
                    end
                end
                S_FALL: begin
                    // The lobe limit is never positive, so a clamp also lands at or below zero.
                    outn_q <= (y_ext > 17'sd0) && (fall_sum <= 17'sd0);
                    if (fall_sum < neg_lim) begin
                        y_q     <= neg_lim[15:0];
                        state_q <= S_RETURN;
                    end else begin
                        y_q <= fall_sum[15:0];
                    end
                end
                S_RETURN: begin
                    // outP marks the return to baseline, so a tiny amp whose lobe
                    // clamps at zero still yields its single outP.
                    if (ret_sum >= 17'sd0) begin
                        y_q     <= '0;
                        outp_q  <= 1'b1;
                        hold_q  <= HOLD_W'(HOLD_INIT);
                        state_q <= S_HOLDOFF;
                    end else begin
                        y_q <= ret_sum[15:0];
                    end
                end
                S_HOLDOFF: begin
                    y_q <= '0;
                    if (hold_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    y_q     <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y      = y_q;
    assign bus.outN   = outn_q;
    assign bus.outP   = outp_q;
    assign bus.busy   = busy_q;
    assign bus.missed = missed_q;
endmodule

// File: tb/tb_bipolar_pulse_gen.sv
// Directed bench for bipolar_pulse_gen with hand-computed waveforms at default parameters.
module tb_bipolar_pulse_gen;
    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    bipolar_pulse_gen_if bus_if();

    bipolar_pulse_gen dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // amp=1000 pulse, one entry per clock starting at the accepting edge.
    localparam int N_BIG = 27;
    int exp_big_y [N_BIG] = '{0, 250, 500, 750, 1000, 899, 798, 697, 596, 495, 394,
                              293, 192, 91, -10, -111, -212, -313, -414, -500,
                              -299, -98, 0, 0, 0, 0, 0};
    localparam int BIG_N_IDX  = 14;
    localparam int BIG_P_IDX  = 22;
    localparam int BIG_LAST_B = 25;

    // amp=100 pulse: rise clamps in one step, fall crosses then clamps at -50.
    localparam int N_SMALL = 9;
    int exp_small_y [N_SMALL] = '{0, 100, -1, -50, 0, 0, 0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        bus_if.trig = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus_if.trig = 1'b0;
        bus_if.amp = 15'd0;
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if (bus_if.Y !== 16'sd0) begin
            errors++;
            $display("FAIL reset_y: got %0d expected 0", bus_if.Y);
        end
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.outN !== 1'b0 || bus_if.outP !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b outN=%b outP=%b expected 0 0 0",
                     bus_if.busy, bus_if.outN, bus_if.outP);
        end
        checks++;
        if (bus_if.missed !== 8'd0) begin
            errors++;
            $display("FAIL reset_missed: got %0d expected 0", bus_if.missed);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_pulse();
        for (int i = 0; i < N_BIG; i++) begin
            bus_if.trig = (i == 0);
            bus_if.amp = 15'd1000;
            tick();
            checks++;
            if (bus_if.Y !== 16'(exp_big_y[i]) || bus_if.outN !== (i == BIG_N_IDX) ||
                bus_if.outP !== (i == BIG_P_IDX) || bus_if.busy !== (i <= BIG_LAST_B)) begin
                errors++;
                $display("FAIL pulse_cycle%0d: Y=%0d outN=%b outP=%b busy=%b expected Y=%0d outN=%b outP=%b busy=%b",
                         i, bus_if.Y, bus_if.outN, bus_if.outP, bus_if.busy,
                         exp_big_y[i], (i == BIG_N_IDX), (i == BIG_P_IDX), (i <= BIG_LAST_B));
            end
        end
        bus_if.trig = 1'b0;
        $display("test_single_pulse done (amp=1000)");
    endtask

    task automatic test_missed();
        do_clear();
        for (int i = 0; i < N_BIG; i++) begin
            // Misses at cycles 3, 9 and at the holdoff exit edge; amp=0 at 12 must not count.
            if (i == 0) begin
                bus_if.trig = 1'b1;
                bus_if.amp = 15'd1000;
            end else if (i == 3 || i == 9 || i == 26) begin
                bus_if.trig = 1'b1;
                bus_if.amp = 15'd3000;
            end else if (i == 12) begin
                bus_if.trig = 1'b1;
                bus_if.amp = 15'd0;
            end else begin
                bus_if.trig = 1'b0;
                bus_if.amp = 15'd1000;
            end
            tick();
            checks++;
            if (bus_if.Y !== 16'(exp_big_y[i]) || bus_if.busy !== (i <= BIG_LAST_B)) begin
                errors++;
                $display("FAIL missed_wave%0d: Y=%0d busy=%b expected Y=%0d busy=%b",
                         i, bus_if.Y, bus_if.busy, exp_big_y[i], (i <= BIG_LAST_B));
            end
        end
        bus_if.trig = 1'b0;
        checks++;
        if (bus_if.missed !== 8'd3) begin
            errors++;
            $display("FAIL missed_count: got %0d expected 3", bus_if.missed);
        end
        tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.Y !== 16'sd0) begin
            errors++;
            $display("FAIL missed_no_restart: busy=%b Y=%0d expected busy=0 Y=0", bus_if.busy, bus_if.Y);
        end
        $display("test_missed done");
    endtask

    task automatic test_amp_zero();
        do_clear();
        bus_if.trig = 1'b1;
        bus_if.amp = 15'd0;
        tick();
        tick();
        bus_if.trig = 1'b0;
        checks++;
        if (bus_if.Y !== 16'sd0 || bus_if.busy !== 1'b0 || bus_if.missed !== 8'd0) begin
            errors++;
            $display("FAIL amp_zero: Y=%0d busy=%b missed=%0d expected 0 0 0",
                     bus_if.Y, bus_if.busy, bus_if.missed);
        end
        $display("test_amp_zero done");
    endtask

    task automatic test_small_amp();
        do_clear();
        for (int i = 0; i < N_SMALL; i++) begin
            bus_if.trig = (i == 0);
            bus_if.amp = 15'd100;
            tick();
            checks++;
            if (bus_if.Y !== 16'(exp_small_y[i]) || bus_if.outN !== (i == 2) ||
                bus_if.outP !== (i == 4) || bus_if.busy !== (i <= 7)) begin
                errors++;
                $display("FAIL small_cycle%0d: Y=%0d outN=%b outP=%b busy=%b expected Y=%0d outN=%b outP=%b busy=%b",
                         i, bus_if.Y, bus_if.outN, bus_if.outP, bus_if.busy,
                         exp_small_y[i], (i == 2), (i == 4), (i <= 7));
            end
        end
        bus_if.trig = 1'b0;
        $display("test_small_amp done (amp=100)");
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int i = 0; i <= 8; i++) begin
            bus_if.trig = (i == 0 || i == 3);
            bus_if.amp = 15'd1000;
            tick();
        end
        bus_if.trig = 1'b0;
        checks++;
        if (bus_if.Y !== 16'sd596 || bus_if.missed !== 8'd1) begin
            errors++;
            $display("FAIL clear_pre: Y=%0d missed=%0d expected Y=596 missed=1", bus_if.Y, bus_if.missed);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (bus_if.Y !== 16'sd0 || bus_if.busy !== 1'b0 || bus_if.outN !== 1'b0 ||
            bus_if.outP !== 1'b0 || bus_if.missed !== 8'd0) begin
            errors++;
            $display("FAIL clear_mid: Y=%0d busy=%b outN=%b outP=%b missed=%0d expected 0 0 0 0 0",
                     bus_if.Y, bus_if.busy, bus_if.outN, bus_if.outP, bus_if.missed);
        end
        bus_if.trig = 1'b1;
        tick();
        clr = 1'b0;
        bus_if.trig = 1'b0;
        tick();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.Y !== 16'sd0 || bus_if.outN !== 1'b0 || bus_if.outP !== 1'b0) begin
            errors++;
            $display("FAIL clear_over_trig: busy=%b Y=%0d outN=%b outP=%b expected 0 0 0 0",
                     bus_if.busy, bus_if.Y, bus_if.outN, bus_if.outP);
        end
        $display("test_clear_mid done");
    endtask

    task automatic test_saturate();
        do_clear();
        bus_if.trig = 1'b1;
        bus_if.amp = 15'd1000;
        for (int i = 0; i < 27; i++) tick();
        checks++;
        if (bus_if.missed !== 8'd26 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_first_pulse: missed=%0d busy=%b expected missed=26 busy=0",
                     bus_if.missed, bus_if.busy);
        end
        for (int i = 0; i < 400; i++) tick();
        bus_if.trig = 1'b0;
        checks++;
        if (bus_if.missed !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 255", bus_if.missed);
        end
        $display("test_saturate done");
    endtask

    initial begin
        clr = 1'b1;
        bus_if.trig = 1'b0;
        bus_if.amp = 15'd0;
        test_reset();
        test_single_pulse();
        test_missed();
        test_amp_zero();
        test_small_amp();
        test_clear_mid();
        test_single_pulse();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bipolar_pulse_gen.md
BIPOLAR_PULSE_GEN -- requirements
Module: bipolar_pulse_gen

Interface
REQ-001 Parameter RISE_STEP, default 250, positive slope added per clock during rise.
REQ-002 Parameter FALL_STEP, default 101, amount subtracted per clock during fall.
REQ-003 Parameter NEG_SHIFT, default 1, negative lobe depth = -(amp >> NEG_SHIFT).
REQ-004 Parameter RET_STEP, default 201, amount added per clock during return to baseline.
REQ-005 Parameter HOLD, default 4, holdoff clocks after the pulse ends.
REQ-006 Port clk, input, 1, sole clock; all logic on the posedge.
REQ-007 Port clr, input, 1, synchronous active-high reset.
REQ-008 Port trig, input, 1, pulse start request, sampled on posedge.
REQ-009 Port amp, input, 15, unsigned pulse amplitude, latched on accepted trig.
REQ-010 Port Y, output, 16, signed sample stream, registered.
REQ-011 Port outN, output, 1, one-clock flag: Y has just crossed from >0 to <=0.
REQ-012 Port outP, output, 1, one-clock flag: Y has just crossed from <0 to >=0.
REQ-013 Port busy, output, 1, high in every state except IDLE.
REQ-014 Port missed, output, 8, count of triggers rejected while busy, saturating at 255.

Function
REQ-015 The block SHALL use the states IDLE, RISE, FALL, RETURN and HOLDOFF.
REQ-016 IDLE: Y=0; trig=1 with amp!=0 SHALL latch amp and enter RISE; trig with amp=0 SHALL be ignored and SHALL NOT be counted.
REQ-017 Latency: for trig accepted at edge n, the first nonzero Y SHALL appear after edge n+1.
REQ-018 RISE: Y <= Y+RISE_STEP each clock; if the result is >= amp, Y SHALL be clamped to amp and the state SHALL become FALL.
REQ-019 FALL: Y <= Y-FALL_STEP each clock; if the result is < -(amp>>NEG_SHIFT), Y SHALL be clamped to that value and the state SHALL become RETURN.
REQ-020 RETURN: Y <= Y+RET_STEP each clock; if the result is >= 0, Y SHALL be clamped to 0 and the state SHALL become HOLDOFF.
REQ-021 HOLDOFF: Y=0 for exactly HOLD clocks, then IDLE; HOLD=0 SHALL return to IDLE after one clock.
REQ-022 All arithmetic SHALL be done at 17-bit signed width before clamping, so Y never wraps.
REQ-023 outN SHALL be registered together with Y and be high for exactly the one cycle in which Y first shows <=0 after being >0.
REQ-024 outP SHALL be registered together with Y and be high for exactly the one cycle in which Y first shows >=0 after being <0.
REQ-025 Every pulse SHALL produce exactly one outN and one outP, in that order.
REQ-026 trig while busy SHALL be ignored; missed SHALL increment only if amp!=0, and SHALL hold at 255.
REQ-027 A trig in the same clock as the HOLDOFF to IDLE transition SHALL count as missed.
REQ-028 If RISE_STEP, FALL_STEP or RET_STEP exceeds the remaining distance, the single-step clamp rule SHALL apply.

Reset
REQ-029 With clr=1 at a posedge: state=IDLE, Y=0, outN=0, outP=0, busy=0, missed=0, and the latched amp cleared.
REQ-030 clr SHALL override trig in the same cycle.
REQ-031 clr mid-pulse SHALL drive Y to 0 immediately with no crossing flag.

Verification
REQ-032 Default parameters, amp=1000, one trig -> Y: 250, 500, 750, 1000, 899, 798, ... ; outN with Y=-10.
REQ-033 Same pulse continued -> clamp at -500; then Y: -299, -98, 0; outP with Y=0; busy for 4 more clocks; then busy=0.
REQ-034 trig pulsed 3 times during a pulse (amp=1000) -> missed=3; Y waveform unchanged.
REQ-035 amp=0 trig in IDLE -> Y stays 0, busy=0, missed unchanged.
REQ-036 clr asserted during FALL with Y=596 -> next cycle Y=0, busy=0, no outN/outP; a new trig afterwards starts a clean pulse.
REQ-037 300 triggers while busy -> missed saturates at 255.
